// File: rtl/dsp_mult_share_arb.sv
// dsp_mult_share_arb
//   Shares one pipelined A_W x B_W unsigned multiplier among NUM_REQ clients.
//   A round-robin arbiter grants at most one request per cycle. Each request
//   is either a plain multiply or a multiply-accumulate into a per-requester
//   accumulator. Results return tagged with the requester id 3 cycles after
//   the handshake.
//
// Ports
//   clk, reset            clock / synchronous active-high reset
//   en                    grant enable (low: no new grants, pipeline drains)
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_acc               per-requester op select: 0 multiply, 1 MAC
//   req_a, req_b          flattened operands, requester i at [i*W +: W]
//   acc_clr               per-requester accumulator clear pulse
//   rsp_valid/id/z        one-cycle result strobe, id and value (id/z hold)
//   busy                  any pipeline stage holds a valid op

// Per-requester accumulator. The MAC writeback value already has any
// coincident clear folded in, so a write takes priority over a clear here.
module dsp_mult_share_acc #(
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [ACC_W-1:0] d_i,
  output logic [ACC_W-1:0] q_o
);
  logic [ACC_W-1:0] acc_q;

  always_ff @(posedge clk) begin
    if (reset)      acc_q <= '0;
    else if (wr_i)  acc_q <= d_i;
    else if (clr_i) acc_q <= '0;
  end

  assign q_o = acc_q;
endmodule

module dsp_mult_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 20,
  parameter int B_W     = 18,
  parameter int ACC_W   = 48
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_acc,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]     acc_clr,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [ACC_W-1:0]       rsp_z,
  output logic                   busy
);
  localparam int P_W    = A_W + B_W;
  localparam int STAGES = 3;

  typedef struct packed {
    logic [A_W-1:0]  a;
    logic [B_W-1:0]  b;
    logic [ID_W-1:0] id;
    logic            mac;
  } s1_t;

  logic [A_W-1:0]   a_arr   [NUM_REQ];
  logic [B_W-1:0]   b_arr   [NUM_REQ];
  logic [ACC_W-1:0] acc_arr [NUM_REQ];

  logic [STAGES:1]  vld_pipe_q;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  s1_t              s1_q;
  logic [P_W-1:0]   prod_q;
  logic [ID_W-1:0]  id2_q;
  logic             mac2_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [ACC_W-1:0] rsp_z_q, rsp_z_d;

  logic [2*NUM_REQ-1:0] rot;
  logic [ID_W-1:0]      off, sel;
  logic [ID_W:0]        sum;
  logic                 found, hs;
  logic [ACC_W-1:0]     prod_ext, acc_base;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*A_W +: A_W];
    assign b_arr[g] = req_b[g*B_W +: B_W];
  end

  // Rotate the request vector so the pointer sits at bit 0, take the lowest
  // set bit, then rotate the offset back to an absolute requester index.
  always_comb begin
    rot   = {req_valid, req_valid} >> ptr_q;
    found = 1'b0;
    off   = '0;
    for (int j = NUM_REQ-1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        off   = ID_W'(j);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
    sel = sum[ID_W-1:0];

    hs        = found & en & ~reset;
    req_ready = '0;
    if (hs) req_ready[sel] = 1'b1;

    ptr_d = ptr_q;
    if (hs) ptr_d = (sel == ID_W'(NUM_REQ-1)) ? '0 : sel + ID_W'(1);
  end

  // Writeback stage: a clear coincident with a MAC to the same requester
  // zeroes the base, so the result becomes just the new product.
  always_comb begin
    prod_ext = ACC_W'(prod_q);
    acc_base = acc_clr[id2_q] ? '0 : acc_arr[id2_q];
    rsp_z_d  = mac2_q ? acc_base + prod_ext : prod_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      ptr_q      <= '0;
      s1_q       <= '0;
      prod_q     <= '0;
      id2_q      <= '0;
      mac2_q     <= 1'b0;
      rsp_id_q   <= '0;
      rsp_z_q    <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], hs};
      ptr_q      <= ptr_d;
      if (hs) begin
        s1_q.a   <= a_arr[sel];
        s1_q.b   <= b_arr[sel];
        s1_q.id  <= sel;
        s1_q.mac <= req_acc[sel];
      end
      prod_q <= s1_q.a * s1_q.b;
      id2_q  <= s1_q.id;
      mac2_q <= s1_q.mac;
      if (vld_pipe_q[2]) begin
        rsp_id_q <= id2_q;
        rsp_z_q  <= rsp_z_d;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_acc
    dsp_mult_share_acc #(.ACC_W(ACC_W)) u_acc (
      .clk   (clk),
      .reset (reset),
      .clr_i (acc_clr[g]),
      .wr_i  (vld_pipe_q[2] & mac2_q & (id2_q == ID_W'(g))),
      .d_i   (rsp_z_d),
      .q_o   (acc_arr[g])
    );
  end

  assign rsp_valid = vld_pipe_q[STAGES];
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;
  assign busy      = |vld_pipe_q;
endmodule

// File: tb/tb_dsp_mult_share_arb.sv
module tb_dsp_mult_share_arb;
  localparam int NR = 4, IDW = 2, AW = 20, BW = 18, ACCW = 48;

  logic              clk = 1'b0;
  logic              reset, en;
  logic [NR-1:0]     req_valid, req_ready, req_acc, acc_clr;
  logic [NR*AW-1:0]  req_a;
  logic [NR*BW-1:0]  req_b;
  logic              rsp_valid, busy;
  logic [IDW-1:0]    rsp_id;
  logic [ACCW-1:0]   rsp_z;

  int n_vec = 0, n_err = 0;

  dsp_mult_share_arb #(.NUM_REQ(NR), .ID_W(IDW), .A_W(AW), .B_W(BW), .ACC_W(ACCW)) dut (
    .clk(clk), .reset(reset), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_acc(req_acc),
    .req_a(req_a), .req_b(req_b), .acc_clr(acc_clr),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b, input logic mac);
    req_valid[i]         = 1'b1;
    req_acc[i]           = mac;
    req_a[i*AW +: AW]    = a;
    req_b[i*BW +: BW]    = b;
  endtask

  task automatic rsp(input string tag, input int id, input logic [ACCW-1:0] z);
    chk({tag, ".v"},  64'(rsp_valid), 64'd1);
    chk({tag, ".id"}, 64'(rsp_id),    64'(id));
    chk({tag, ".z"},  64'(rsp_z),     64'(z));
  endtask

  // Issue one op alone, check its grant, and check its response 3 cycles on.
  task automatic single(input string tag, input int i, input logic [AW-1:0] a,
                        input logic [BW-1:0] b, input logic mac, input logic [ACCW-1:0] z);
    req_valid = '0;
    op(i, a, b, mac);
    #1 chk({tag, ".rdy"}, 64'(req_ready), 64'(1) << i);
    nxt; req_valid = '0;
    nxt; nxt;
    rsp(tag, i, z);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; req_valid = '1; req_acc = '0;
    req_a = '0; req_b = '0; acc_clr = '0;
    nxt; nxt;
    chk("rst.rdy",  64'(req_ready), 64'd0);
    chk("rst.v",    64'(rsp_valid), 64'd0);
    chk("rst.id",   64'(rsp_id),    64'd0);
    chk("rst.z",    64'(rsp_z),     64'd0);
    chk("rst.busy", 64'(busy),      64'd0);
    reset = 1'b0;

    // Fairness: all four requesting plain multiplies (i+1)*10.
    for (int i = 0; i < NR; i++) op(i, AW'(i+1), 18'd10, 1'b0);
    for (int k = 0; k < 11; k++) begin
      if (k == 8) req_valid = '0;
      #1;
      if (k < 8) chk($sformatf("fair.rdy%0d", k), 64'(req_ready), 64'(1) << (k % 4));
      if (k >= 3) rsp($sformatf("fair.r%0d", k-3), (k-3) % 4, ACCW'((((k-3) % 4) + 1) * 10));
      nxt;
    end
    chk("fair.v_end",    64'(rsp_valid), 64'd0);
    chk("fair.busy_end", 64'(busy),      64'd0);

    // Full-scale multiply: (2^20-1)*(2^18-1) = 2^38 - 2^20 - 2^18 + 1.
    single("mul", 0, 20'hFFFFF, 18'h3FFFF, 1'b0, 48'h003F_FFEC_0001);
    nxt;
    chk("mul.v_after", 64'(rsp_valid), 64'd0);
    chk("mul.z_hold",  64'(rsp_z),     64'h003F_FFEC_0001);
    chk("mul.busy",    64'(busy),      64'd0);
    // acc[0] untouched by the multiply
    single("mac0", 0, 20'd2, 18'd3, 1'b1, 48'd6);

    // Back-to-back MAC chain on requester 2.
    req_valid = '0;
    op(2, 20'd3, 18'd5, 1'b1);   nxt;
    op(2, 20'd7, 18'd2, 1'b1);   nxt;
    op(2, 20'd10, 18'd10, 1'b1); nxt;
    req_valid = '0;
    rsp("chain0", 2, 48'd15);  nxt;
    rsp("chain1", 2, 48'd29);  nxt;
    rsp("chain2", 2, 48'd129);

    // Standalone clear on requester 2.
    acc_clr = 4'b0100; nxt; acc_clr = '0;
    single("clr2", 2, 20'd1, 18'd1, 1'b1, 48'd1);

    // Clear colliding with MAC writeback on requester 1.
    single("pre1", 1, 20'd10, 18'd10, 1'b1, 48'd100);
    req_valid = '0;
    op(1, 20'd4, 18'd4, 1'b1); nxt;
    req_valid = '0;            nxt;
    acc_clr = 4'b0010;         nxt;
    acc_clr = '0;
    rsp("coll", 1, 48'd16);
    single("coll_next", 1, 20'd1, 18'd1, 1'b1, 48'd17);

    // en drops after a grant: no new grant, in-flight op completes.
    req_valid = '0;
    op(0, 20'd3, 18'd3, 1'b0);
    #1 chk("en.rdy1", 64'(req_ready), 64'd1);
    nxt; en = 1'b0;
    #1 chk("en.rdy0", 64'(req_ready), 64'd0);
    nxt; req_valid = '0;
    nxt;
    rsp("en", 0, 48'd9);
    en = 1'b1;

    // Wrap: 4095 MACs of 2^36 then one of (2^36-1) leaves acc[3] = 2^48-1.
    req_valid = '0;
    for (int k = 0; k < 4096; k++) begin
      if (k < 4095) op(3, 20'h80000, 18'h20000, 1'b1);
      else          op(3, 20'h40001, 18'h3FFFF, 1'b1);
      nxt;
    end
    req_valid = '0;
    rsp("wrap.mid", 3, 48'hFFE0_0000_0000);
    nxt; nxt;
    rsp("wrap.full", 3, 48'hFFFF_FFFF_FFFF);
    single("wrap", 3, 20'd1, 18'd1, 1'b1, 48'd0);

    // Reset one cycle after a handshake kills the op and the pointer.
    req_valid = '0;
    op(0, 20'd5, 18'd5, 1'b0);
    nxt;
    reset = 1'b1; req_valid = 4'b1001;
    #1 chk("rmid.rdy_rst", 64'(req_ready), 64'd0);
    nxt;
    reset = 1'b0;
    chk("rmid.v",    64'(rsp_valid), 64'd0);
    chk("rmid.id",   64'(rsp_id),    64'd0);
    chk("rmid.z",    64'(rsp_z),     64'd0);
    chk("rmid.busy", 64'(busy),      64'd0);
    #1 chk("rmid.rdy", 64'(req_ready), 64'd1);
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      nxt;
      chk($sformatf("rmid.nov%0d", k), 64'(rsp_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
